// File: rtl/rx_cmd_ctrl.sv
// Byte-stream command decoder: turns received bytes into register-file writes/reads and ALU starts.
// Optional inter-byte timeout is compiled in when RX_CMD_CTRL_TIMEOUT_EN is defined.
module rx_cmd_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int NUM_OPS     = 2,
    parameter int TIMEOUT_CYC = 255,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Rx_P_Data,
    input  logic             RxValid,
    input  logic             Rx_Err,
    output logic             ALU_EN,
    output logic [3:0]       ALU_FUN,
    output logic [AW-1:0]    Reg_File_Adress,
    output logic             WrEN,
    output logic             RdEN,
    output logic [WIDTH-1:0] WrData,
    output logic             CLK_GATE_EN,
    output logic             Busy,
    output logic             Cmd_Done,
    output logic             Cmd_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_RADDR,
        S_OPND,
        S_FUN
    } state_t;

    localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] CMD_OPS = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] CMD_FUN = WIDTH'(8'hDD);

    state_t           state, state_nxt;
    logic [AW-1:0]    addr_lat, addr_lat_nxt;
    logic [1:0]       op_cnt, op_cnt_nxt;
    logic             accept, rx_bad, in_range, fun_ok, tmo_hit;
    logic             alu_en_nxt, wr_en_nxt, rd_en_nxt, done_nxt, err_nxt;
    logic [3:0]       alu_fun_nxt;
    logic [AW-1:0]    adr_nxt;
    logic [WIDTH-1:0] wdata_nxt;

    assign accept   = RxValid && !Rx_Err;
    assign rx_bad   = RxValid && Rx_Err;
    // Widened compare so DEPTH values beyond the byte range still behave.
    assign in_range = ({32'd0, Rx_P_Data} < (WIDTH + 32)'(DEPTH));
    assign fun_ok   = (Rx_P_Data[WIDTH-1:4] == '0);

`ifdef RX_CMD_CTRL_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (state != S_IDLE) && !accept && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            tmo_cnt <= '0;
        end else if (state_nxt == S_IDLE || accept) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        addr_lat_nxt = addr_lat;
        op_cnt_nxt   = op_cnt;
        alu_en_nxt   = 1'b0;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        alu_fun_nxt  = ALU_FUN;
        adr_nxt      = Reg_File_Adress;
        wdata_nxt    = WrData;

        if (state != S_IDLE && rx_bad) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end else if (accept) begin
            case (state)
                S_IDLE: begin
                    if (Rx_P_Data == CMD_WR) begin
                        state_nxt = S_WADDR;
                    end else if (Rx_P_Data == CMD_RD) begin
                        state_nxt = S_RADDR;
                    end else if (Rx_P_Data == CMD_OPS) begin
                        state_nxt  = S_OPND;
                        op_cnt_nxt = '0;
                    end else if (Rx_P_Data == CMD_FUN) begin
                        state_nxt = S_FUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                S_WADDR: begin
                    if (in_range) begin
                        addr_lat_nxt = Rx_P_Data[AW-1:0];
                        state_nxt    = S_WDATA;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_WDATA: begin
                    wr_en_nxt = 1'b1;
                    adr_nxt   = addr_lat;
                    wdata_nxt = Rx_P_Data;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_RADDR: begin
                    if (in_range) begin
                        rd_en_nxt = 1'b1;
                        adr_nxt   = Rx_P_Data[AW-1:0];
                        done_nxt  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end
                S_OPND: begin
                    wr_en_nxt  = 1'b1;
                    adr_nxt    = AW'(op_cnt);
                    wdata_nxt  = Rx_P_Data;
                    op_cnt_nxt = op_cnt + 2'd1;
                    if (op_cnt == 2'(NUM_OPS - 1)) begin
                        state_nxt = S_FUN;
                    end
                end
                S_FUN: begin
                    if (fun_ok) begin
                        alu_en_nxt  = 1'b1;
                        alu_fun_nxt = Rx_P_Data[3:0];
                        done_nxt    = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // A silent link aborts the command; a byte in the same cycle takes precedence.
        if (tmo_hit) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state           <= S_IDLE;
            addr_lat        <= '0;
            op_cnt          <= '0;
            ALU_EN          <= 1'b0;
            WrEN            <= 1'b0;
            RdEN            <= 1'b0;
            Cmd_Done        <= 1'b0;
            Cmd_Err         <= 1'b0;
            ALU_FUN         <= '0;
            Reg_File_Adress <= '0;
            WrData          <= '0;
        end else begin
            state           <= state_nxt;
            addr_lat        <= addr_lat_nxt;
            op_cnt          <= op_cnt_nxt;
            ALU_EN          <= alu_en_nxt;
            WrEN            <= wr_en_nxt;
            RdEN            <= rd_en_nxt;
            Cmd_Done        <= done_nxt;
            Cmd_Err         <= err_nxt;
            ALU_FUN         <= alu_fun_nxt;
            Reg_File_Adress <= adr_nxt;
            WrData          <= wdata_nxt;
        end
    end

    assign Busy        = (state != S_IDLE);
    assign CLK_GATE_EN = (state == S_FUN) || ALU_EN;

endmodule
